// File: rtl/spi_responder.sv
// Byte-level CPHA=0 SPI target, oversampled on CLK, with parallel rx/tx handshake.
// Define SPI_RESP_STATUS_EN to send a status byte as the first byte of each selection.
module spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter bit          CPOL        = 1'b0,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       SCK,
    input  logic       nSS,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] RXDATA,
    output logic       RXVALID,
    input  logic       RXACK,
    output logic       OVERRUN,
    input  logic [7:0] TXDATA,
    input  logic       TXLOAD,
    output logic       TXREADY,
    output logic       SEL
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_q, nss_q, mosi_q;
    logic       sck_prev_q;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] buf_q, buf_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic       miso_q, miso_d;
    logic       rxvalid_q, rxvalid_d;
    logic       overrun_q, overrun_d;
    logic       txready_q, txready_d;

    logic sck_s, nss_s, mosi_s;
    logic sck_edge, lead, trail, reload;

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign nss_s    = nss_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign sck_edge = sck_s ^ sck_prev_q;
    assign lead     = sck_edge & (sck_s != CPOL);
    assign trail    = sck_edge & (sck_s == CPOL);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sck_q      <= {SYNC_STAGES{CPOL}};
            nss_q      <= '1;
            mosi_q     <= '0;
            sck_prev_q <= CPOL;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], SCK};
            nss_q      <= {nss_q[SYNC_STAGES-2:0], nSS};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q <= sck_s;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= IDLE_BYTE;
            buf_q     <= '0;
            rxdata_q  <= '0;
            miso_q    <= IDLE_BYTE[7];
            rxvalid_q <= 1'b0;
            overrun_q <= 1'b0;
            txready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            buf_q     <= buf_d;
            rxdata_q  <= rxdata_d;
            miso_q    <= miso_d;
            rxvalid_q <= rxvalid_d;
            overrun_q <= overrun_d;
            txready_q <= txready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        buf_d     = buf_q;
        rxdata_d  = rxdata_q;
        miso_d    = miso_q;
        rxvalid_d = rxvalid_q;
        overrun_d = overrun_q;
        txready_d = txready_q;
        reload    = 1'b0;

        if (RXACK) begin
            rxvalid_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (TXLOAD && txready_q) begin
            buf_d     = TXDATA;
            txready_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                rx_d   = '0;
                miso_d = IDLE_BYTE[7];
                if (!nss_s) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (nss_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                    reload  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (nss_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                    miso_d  = IDLE_BYTE[7];
                end else if (lead) begin
                    rx_d  = {rx_q[5:0], mosi_s};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (!rxvalid_q || RXACK) begin
                            rxdata_d  = {rx_q, mosi_s};
                            rxvalid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (trail) begin
                    if (cnt_q == 3'd0) begin
                        reload = 1'b1;
                    end else begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        miso_d = tx_q[6];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reload sees txready_q from before any same-cycle TXLOAD write.
        if (reload) begin
`ifdef SPI_RESP_STATUS_EN
            if (state_q == S_LOAD) begin
                tx_d = {txready_q, rxvalid_q, overrun_q, 5'b00000};
            end else
`endif
            if (!txready_q) begin
                tx_d      = buf_q;
                txready_d = 1'b1;
            end else begin
                tx_d = IDLE_BYTE;
            end
            miso_d = tx_d[7];
        end
    end

    assign MISO    = miso_q;
    assign RXDATA  = rxdata_q;
    assign RXVALID = rxvalid_q;
    assign OVERRUN = overrun_q;
    assign TXREADY = txready_q;
    assign SEL     = ~nss_s;

endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: a bit-banged master with CPOL=0,
// checking MISO byte streams and the parallel rx/tx handshake.
module tb_spi_responder;

    localparam int H = 6;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       SCK = 1'b0;
    logic       nSS = 1'b1;
    logic       MOSI = 1'b0;
    logic       RXACK = 1'b0;
    logic       TXLOAD = 1'b0;
    logic [7:0] TXDATA = 8'h00;
    logic       MISO, RXVALID, OVERRUN, TXREADY, SEL;
    logic [7:0] RXDATA;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    spi_responder dut (
        .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .nSS(nSS), .MOSI(MOSI),
        .MISO(MISO), .RXDATA(RXDATA), .RXVALID(RXVALID), .RXACK(RXACK),
        .OVERRUN(OVERRUN), .TXDATA(TXDATA), .TXLOAD(TXLOAD),
        .TXREADY(TXREADY), .SEL(SEL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sel();
        nSS = 1'b0;
        cyc(8);
    endtask

    task automatic desel();
        nSS = 1'b1;
        cyc(8);
    endtask

    task automatic ack();
        RXACK = 1'b1;
        cyc(1);
        RXACK = 1'b0;
        cyc(1);
    endtask

    task automatic txload(input logic [7:0] d);
        TXDATA = d;
        TXLOAD = 1'b1;
        cyc(1);
        TXLOAD = 1'b0;
    endtask

    // ack_last raises RXACK in the cycle the DUT sees the 8th leading edge.
    task automatic xfer(input logic [7:0] mo, input logic [7:0] mi_exp,
                        input int nbits, input bit ack_last);
        logic [7:0] got;
        logic [7:0] exp;
        got = 8'h00;
        if (nbits == 8) exp_q.push_back(mi_exp);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            cyc(2);
            SCK = 1'b1;
            got = {got[6:0], MISO};
            if (ack_last && i == 7) begin
                cyc(2);
                RXACK = 1'b1;
                cyc(1);
                RXACK = 1'b0;
                cyc(H-3);
            end else begin
                cyc(H);
            end
            SCK = 1'b0;
            cyc(H-2);
        end
        if (nbits == 8) begin
            exp = exp_q.pop_front();
            check("miso_byte", got, exp);
        end
    endtask

    initial begin
        cyc(3);
        check("rst_miso", MISO, 1);
        check("rst_rxdata", RXDATA, 8'h00);
        check("rst_rxvalid", RXVALID, 0);
        check("rst_overrun", OVERRUN, 0);
        check("rst_txready", TXREADY, 1);
        check("rst_sel", SEL, 0);
        nRESET = 1'b1;
        cyc(2);

        sel();
        check("t1_sel", SEL, 1);
        xfer(8'hA5, 8'hFF, 8, 0);
        cyc(4);
        check("t1_rxdata", RXDATA, 8'hA5);
        check("t1_rxvalid", RXVALID, 1);
        check("t1_txready", TXREADY, 1);
        desel();
        check("t1_desel", SEL, 0);
        check("t1_miso_idle", MISO, 1);
        ack();
        check("t1_ack", RXVALID, 0);

        txload(8'h3C);
        check("t2_txr0", TXREADY, 0);
        txload(8'h99);
        nSS = 1'b0;
        cyc(3);
        check("t2_txr_preload", TXREADY, 0);
        cyc(1);
        check("t2_txr_load", TXREADY, 1);
        check("t2_miso_b7", MISO, 0);
        cyc(4);
        xfer(8'h00, 8'h3C, 8, 0);
        cyc(4);
        check("t2_rxdata", RXDATA, 8'h00);
        desel();
        ack();

        sel();
        xfer(8'h11, 8'hFF, 8, 0);
        xfer(8'h22, 8'hFF, 8, 0);
        cyc(4);
        check("t3_rxdata", RXDATA, 8'h11);
        check("t3_rxvalid", RXVALID, 1);
        check("t3_overrun", OVERRUN, 1);
        desel();
        ack();
        check("t3_ack_rxv", RXVALID, 0);
        check("t3_ack_ovr", OVERRUN, 0);

        sel();
        xfer(8'h33, 8'hFF, 8, 0);
        cyc(4);
        check("t4_first", RXDATA, 8'h33);
        xfer(8'h22, 8'hFF, 8, 1);
        cyc(4);
        check("t4_rxdata", RXDATA, 8'h22);
        check("t4_rxvalid", RXVALID, 1);
        check("t4_overrun", OVERRUN, 0);
        desel();
        ack();

        sel();
        xfer(8'hA8, 8'h00, 5, 0);
        desel();
        check("t5_partial_rxv", RXVALID, 0);
        check("t5_partial_rxd", RXDATA, 8'h22);
        sel();
        xfer(8'h81, 8'hFF, 8, 0);
        cyc(4);
        check("t5_rxdata", RXDATA, 8'h81);
        check("t5_rxvalid", RXVALID, 1);
        desel();

        sel();
        xfer(8'h44, 8'hFF, 8, 0);
        cyc(4);
        check("t6_overrun", OVERRUN, 1);
        txload(8'h5A);
        check("t6_txr", TXREADY, 0);
        xfer(8'hE0, 8'h00, 3, 0);
        nRESET = 1'b0;
        #2;
        check("t6_miso", MISO, 1);
        check("t6_rxdata", RXDATA, 8'h00);
        check("t6_rxvalid", RXVALID, 0);
        check("t6_overrun", OVERRUN, 0);
        check("t6_txready", TXREADY, 1);
        check("t6_sel", SEL, 0);
        nSS = 1'b1;
        SCK = 1'b0;
        cyc(2);
        nRESET = 1'b1;
        cyc(2);
        sel();
        xfer(8'h7E, 8'hFF, 8, 0);
        cyc(4);
        check("t6_rxdata2", RXDATA, 8'h7E);
        check("t6_rxvalid2", RXVALID, 1);
        check("t6_overrun2", OVERRUN, 0);
        check("t6_txready2", TXREADY, 1);
        desel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
